data_mem_responder: RTL

- Data-memory responder for the pipeline's MEM stage. The pipeline's load/store unit is the initiator; this block is the memory end of that request/response handshake.
- Accepts one RV32I load or store at a time, applies byte-lane selection and sign/zero extension per funct3, and returns data or an error after a fixed latency.
- Sits beside the existing instruction memory, replacing a combinational data memory so stalls on the request/response handshake can be exercised.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/lsu_aligner.sv | 59 +++++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and the data-memory responder state type.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

endpackage

// File: rtl/lsu_aligner.sv
// Byte-lane steering for RV32I loads/stores: write enables, positioned store
// data, extended load data and a flag for misaligned or illegal accesses.
module lsu_aligner
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = read_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    write_word = 32'h0;
    load_data  = 32'h0;
    fault      = 1'b0;
    case (funct3)
      F3_LB: begin
        byte_en    = 4'b0001 << addr_lo;
        write_word = {4{wdata[7:0]}};
        load_data  = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_LH: begin
        fault      = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        write_word = {2{wdata[15:0]}};
        load_data  = {{16{sel_half[15]}}, sel_half};
      end
      F3_LW: begin
        fault      = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        write_word = wdata;
        load_data  = read_word;
      end
      // Unsigned variants exist only as loads.
      F3_LBU: begin
        fault     = write;
        load_data = {24'h0, sel_byte};
      end
      F3_LHU: begin
        fault     = write | addr_lo[0];
        load_data = {16'h0, sel_half};
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory behind a valid/ready request/response handshake with
// a fixed response latency; one outstanding request at a time.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_START  = 4'(LATENCY - 1);

  dm_state_t   state, state_next;
  logic [3:0]  count;
  logic        hold_write;
  logic [2:0]  hold_funct3;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit, in_idle;
  logic          op_write;
  logic [2:0]    op_funct3;
  logic [31:0]   op_addr, op_wdata;
  logic [AW-1:0] op_index;
  logic [31:0]   read_word, write_word, load_data;
  logic [3:0]    byte_en;
  logic          fault, op_error;

  assign in_idle = (state == DM_IDLE);
  assign accept  = req_valid && req_ready;

  // With LATENCY==1 the commit edge is the acceptance edge, so the live
  // request feeds the datapath instead of the holding registers.
  assign op_write  = in_idle ? req_write  : hold_write;
  assign op_funct3 = in_idle ? req_funct3 : hold_funct3;
  assign op_addr   = in_idle ? req_addr   : hold_addr;
  assign op_wdata  = in_idle ? req_wdata  : hold_wdata;

  assign op_index  = op_addr[AW+1:2];
  assign read_word = mem[op_index];
  assign op_error  = fault || (op_addr >= BYTE_LIMIT);
  assign commit    = reset && ((state == DM_WAIT && count == 4'd1) ||
                               (in_idle && accept && LATENCY == 1));

  lsu_aligner u_aligner (
    .funct3     (op_funct3),
    .write      (op_write),
    .addr_lo    (op_addr[1:0]),
    .wdata      (op_wdata),
    .read_word  (read_word),
    .byte_en    (byte_en),
    .write_word (write_word),
    .load_data  (load_data),
    .fault      (fault)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= DM_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DM_IDLE: if (accept) state_next = (LATENCY == 1) ? DM_RESP : DM_WAIT;
      DM_WAIT: if (count == 4'd1) state_next = DM_RESP;
      DM_RESP: if (resp_ready) state_next = DM_IDLE;
      default: state_next = DM_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = in_idle && reset;
    resp_valid = (state == DM_RESP);
    busy       = (state == DM_WAIT) || (state == DM_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count       <= 4'd0;
      hold_write  <= 1'b0;
      hold_funct3 <= 3'b000;
      hold_addr   <= 32'h0;
      hold_wdata  <= 32'h0;
    end else if (accept) begin
      count       <= CNT_START;
      hold_write  <= req_write;
      hold_funct3 <= req_funct3;
      hold_addr   <= req_addr;
      hold_wdata  <= req_wdata;
    end else if (state == DM_WAIT) begin
      count <= count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else if (commit) begin
      resp_rdata <= (op_error || op_write) ? 32'h0 : load_data;
      resp_error <= op_error;
    end
  end

  // Memory contents survive reset; only committed, error-free stores write.
  always_ff @(posedge clk) begin
    if (commit && op_write && !op_error) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[op_index][8*i +: 8] <= write_word[8*i +: 8];
      end
    end
  end

endmodule
